// File: rtl/gen_edge_detect_n.sv
// Multi-channel input conditioner: synchronizer, glitch filter and qualified
// edge detector per channel, with sticky edge/overrun flags and a post-reset arming window.
module gen_edge_detect_n #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_CH-1:0]     sig,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [FILT_W-1:0]     filt_len,
  input  logic [NUM_CH-1:0]     clear,
  output logic [NUM_CH-1:0]     sig_level,
  output logic [NUM_CH-1:0]     sig_edge,
  output logic [NUM_CH-1:0]     edge_flag,
  output logic [NUM_CH-1:0]     overrun
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed;
  logic [FILT_W:0]  thresh;

  always_comb begin
    armed     = (arm_cnt_q == ARM_W'(SYNC_STAGES));
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
    // A filter length of zero behaves like one: the first differing sample is accepted.
    thresh    = (filt_len == '0) ? (FILT_W+1)'(1) : {1'b0, filt_len};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      arm_cnt_q <= '0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILT_W-1:0]      cnt_q, cnt_d;
    logic [FILT_W:0]        cnt_inc;
    logic [1:0]             ch_mode;
    logic                   sync_last;
    logic                   level_q, level_d;
    logic                   edge_q, edge_d;
    logic                   flag_q, flag_d;
    logic                   ovr_q, ovr_d;

    always_comb begin
      ch_mode   = mode[2*gi +: 2];
      sync_d    = {sync_q[SYNC_STAGES-2:0], sig[gi]};
      sync_last = sync_q[SYNC_STAGES-1];
      cnt_inc   = {1'b0, cnt_q} + (FILT_W+1)'(1);
      level_d   = level_q;
      cnt_d     = '0;
      edge_d    = 1'b0;

      if (!armed) begin
        // Follow the chain's incoming value so the level is settled when arming ends.
        level_d = sync_d[SYNC_STAGES-1];
      end else if (sync_last != level_q) begin
        if (cnt_inc >= thresh) begin
          level_d = sync_last;
          edge_d  = level_q ? ch_mode[1] : ch_mode[0];
        end else begin
          cnt_d = cnt_inc[FILT_W-1:0];
        end
      end

      flag_d = (flag_q & ~clear[gi]) | edge_q;
      // A new overrun wins over a clear arriving in the same cycle.
      ovr_d  = (edge_q & flag_q) | (ovr_q & ~clear[gi]);
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        sync_q  <= '1;
        level_q <= 1'b1;
        cnt_q   <= '0;
        edge_q  <= 1'b0;
        flag_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        level_q <= level_d;
        cnt_q   <= cnt_d;
        edge_q  <= edge_d;
        flag_q  <= flag_d;
        ovr_q   <= ovr_d;
      end
    end

    assign sig_level[gi] = level_q;
    assign sig_edge[gi]  = edge_q;
    assign edge_flag[gi] = flag_q;
    assign overrun[gi]   = ovr_q;
  end

endmodule

// File: tb/tb_gen_edge_detect_n.sv
// Bench for gen_edge_detect_n: directed vector table, hand-written corner sequences,
// and randomized stimulus against a history-based reference model.
module tb_gen_edge_detect_n;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int FW   = 4;
  localparam int HMAX = 4096;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [NCH-1:0]  sig;
  logic [2*NCH-1:0] mode;
  logic [FW-1:0]   filt_len;
  logic [NCH-1:0]  clear;
  logic [NCH-1:0]  sig_level, sig_edge, edge_flag, overrun;

  gen_edge_detect_n #(.NUM_CH(NCH), .SYNC_STAGES(SYNC), .FILT_W(FW)) dut (
    .clk(clk), .n_rst(n_rst), .sig(sig), .mode(mode), .filt_len(filt_len),
    .clear(clear), .sig_level(sig_level), .sig_edge(sig_edge),
    .edge_flag(edge_flag), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: keeps the raw input history since reset and derives the
  // filtered level from run lengths of disagreeing synchronized samples.
  logic [NCH-1:0] hist [0:HMAX-1];
  int             e;
  int             last_chg [NCH];
  logic [NCH-1:0] m_level, m_edge, m_flag, m_ovr;

  task automatic model_reset();
    e = 0;
    m_level = '1; m_edge = '0; m_flag = '0; m_ovr = '0;
    for (int ch = 0; ch < NCH; ch++) last_chg[ch] = 0;
  endtask

  // Synchronized value of channel ch just after edge j (reset value is 1).
  function automatic logic syncval(input int j, input int ch);
    int k;
    k = j - SYNC + 1;
    if (k < 1) return 1'b1;
    return hist[k][ch];
  endfunction

  task automatic model_step();
    logic [NCH-1:0] nl, ne, nf, no;
    int th, run, j;
    e++;
    hist[e] = sig;
    th = (filt_len == 0) ? 1 : int'(filt_len);
    nl = m_level; ne = '0; nf = '0; no = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      nf[ch] = (m_flag[ch] & ~clear[ch]) | m_edge[ch];
      no[ch] = (m_edge[ch] & m_flag[ch]) | (m_ovr[ch] & ~clear[ch]);
      if (e <= SYNC) begin
        nl[ch] = syncval(e, ch);
      end else begin
        run = 0; j = e;
        while (j > last_chg[ch] && j > SYNC && syncval(j - 1, ch) != m_level[ch]) begin
          run++; j--;
        end
        if (run >= th) begin
          nl[ch] = ~m_level[ch];
          ne[ch] = m_level[ch] ? mode[2*ch+1] : mode[2*ch];
          last_chg[ch] = e;
        end
      end
    end
    m_level = nl; m_edge = ne; m_flag = nf; m_ovr = no;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_level"}, sig_level, m_level);
    chk({tag, "_edge"},  sig_edge,  m_edge);
    chk({tag, "_flag"},  edge_flag, m_flag);
    chk({tag, "_ovr"},   overrun,   m_ovr);
  endtask

  task automatic wait_edge(input int ch, input string name);
    int n = 0;
    do begin tick(); n++; end while (!sig_edge[ch] && n < 20);
    chk(name, 32'(sig_edge[ch]), 32'd1);
  endtask

  typedef struct packed {
    logic [NCH-1:0]   s;
    logic [2*NCH-1:0] md;
    logic [FW-1:0]    fl;
    logic [NCH-1:0]   clr;
    logic [NCH-1:0]   lvl, edg, flg, ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] s, input logic [7:0] md, input logic [3:0] fl,
                     input logic [3:0] clr, input logic [3:0] lvl, input logic [3:0] edg,
                     input logic [3:0] flg, input logic [3:0] ovr);
    tbl.push_back('{s, md, fl, clr, lvl, edg, flg, ovr});
  endtask

  initial begin
    int pc;
    int hold [NCH];

    // ch0 rising, filt_len 0: level/pulse after third edge, flag next, then clear.
    repeat (2) add(4'h1, 8'h01, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 8'h01, 4'd0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
    repeat (2) add(4'h1, 8'h01, 4'd0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0);
    add(4'h1, 8'h01, 4'd0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h1, 8'h01, 4'd0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    // ch1 both-edge mode, filt_len 4: 3-cycle glitch rejected.
    repeat (3) add(4'h3, 8'h0D, 4'd4, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    repeat (4) add(4'h1, 8'h0D, 4'd4, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    // 4-cycle high accepted (pulse 6 edges after change), then falling accepted.
    repeat (4) add(4'h3, 8'h0D, 4'd4, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h1, 8'h0D, 4'd4, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h1, 8'h0D, 4'd4, 4'h0, 4'h3, 4'h2, 4'h0, 4'h0);
    repeat (3) add(4'h1, 8'h0D, 4'd4, 4'h0, 4'h3, 4'h0, 4'h2, 4'h0);
    add(4'h1, 8'h0D, 4'd4, 4'h0, 4'h1, 4'h2, 4'h2, 4'h0);
    repeat (2) add(4'h1, 8'h0D, 4'd4, 4'h0, 4'h1, 4'h0, 4'h2, 4'h2);

    // Reset state
    n_rst = 1'b0; sig = '0; mode = '0; filt_len = '0; clear = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_level", sig_level, 4'hF);
    chk("rst_edge",  sig_edge,  4'h0);
    chk("rst_flag",  edge_flag, 4'h0);
    chk("rst_ovr",   overrun,   4'h0);
    n_rst = 1'b1;

    // Release with all inputs low: no pulses, level settles to 0 by end of arming.
    tick();
    chk("arm1_edge", sig_edge, 4'h0);
    tick();
    chk("arm2_level", sig_level, 4'h0);
    chk("arm2_edge",  sig_edge,  4'h0);
    chk("arm2_flag",  edge_flag, 4'h0);

    // Vector table
    for (int i = 0; i < tbl.size(); i++) begin
      sig = tbl[i].s; mode = tbl[i].md; filt_len = tbl[i].fl; clear = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_level", i), sig_level, tbl[i].lvl);
      chk($sformatf("tbl%0d_edge", i),  sig_edge,  tbl[i].edg);
      chk($sformatf("tbl%0d_flag", i),  edge_flag, tbl[i].flg);
      chk($sformatf("tbl%0d_ovr", i),   overrun,   tbl[i].ovr);
    end
    clear = '0;

    // ch2: two rising edges set overrun; clear during third pulse keeps both; clear alone drops both.
    mode[5:4] = 2'b01; filt_len = 4'd0;
    sig[2] = 1'b1;
    wait_edge(2, "ovr_r1_edge");
    chk("ovr_r1_flag_pre", 32'(edge_flag[2]), 32'd0);
    tick();
    chk("ovr_r1_flag", 32'(edge_flag[2]), 32'd1);
    chk("ovr_r1_ovr",  32'(overrun[2]),   32'd0);
    sig[2] = 1'b0; repeat (5) tick();
    sig[2] = 1'b1;
    wait_edge(2, "ovr_r2_edge");
    tick();
    chk("ovr_r2_flag", 32'(edge_flag[2]), 32'd1);
    chk("ovr_r2_ovr",  32'(overrun[2]),   32'd1);
    sig[2] = 1'b0; repeat (5) tick();
    sig[2] = 1'b1;
    wait_edge(2, "ovr_r3_edge");
    clear[2] = 1'b1;
    tick();
    chk("ovr_r3_flag", 32'(edge_flag[2]), 32'd1);
    chk("ovr_r3_ovr",  32'(overrun[2]),   32'd1);
    tick();
    chk("ovr_clr_flag", 32'(edge_flag[2]), 32'd0);
    chk("ovr_clr_ovr",  32'(overrun[2]),   32'd0);
    clear[2] = 1'b0;

    // ch3 falling-only, then off.
    mode[7:6] = 2'b10; filt_len = 4'd1;
    sig[3] = 1'b1; pc = 0;
    repeat (6) begin tick(); pc += int'(sig_edge[3]); end
    chk("fall_rise_level", 32'(sig_level[3]), 32'd1);
    chk("fall_rise_pulses", pc, 32'd0);
    sig[3] = 1'b0; pc = 0;
    repeat (6) begin tick(); pc += int'(sig_edge[3]); end
    chk("fall_fall_level", 32'(sig_level[3]), 32'd0);
    chk("fall_fall_pulses", pc, 32'd1);
    chk("fall_flag", 32'(edge_flag[3]), 32'd1);
    mode[7:6] = 2'b00; clear[3] = 1'b1; tick(); clear[3] = 1'b0;
    sig[3] = 1'b1; pc = 0;
    repeat (6) begin tick(); pc += int'(sig_edge[3]); end
    chk("off_rise_level", 32'(sig_level[3]), 32'd1);
    sig[3] = 1'b0;
    repeat (6) begin tick(); pc += int'(sig_edge[3]); end
    chk("off_fall_level", 32'(sig_level[3]), 32'd0);
    chk("off_pulses", pc, 32'd0);
    chk("off_flag", 32'(edge_flag[3]), 32'd0);

    // ch0: reset asserted mid-filter aborts the pending rise.
    mode[1:0] = 2'b01; filt_len = 4'd4;
    sig[0] = 1'b0; repeat (10) tick();
    chk("mid_pre_level", 32'(sig_level[0]), 32'd0);
    sig[0] = 1'b1; repeat (4) tick();
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_level", sig_level, 4'hF);
    chk("mid_rst_edge",  sig_edge,  4'h0);
    chk("mid_rst_flag",  edge_flag, 4'h0);
    chk("mid_rst_ovr",   overrun,   4'h0);
    @(negedge clk);
    n_rst = 1'b1;
    pc = 0;
    repeat (10) begin tick(); pc += int'(sig_edge[0]); end
    chk("mid_post_pulses", pc, 32'd0);
    chk("mid_post_level", 32'(sig_level[0]), 32'd1);
    chk_model("mid_post");

    // Randomized stimulus against the reference model.
    for (int ch = 0; ch < NCH; ch++) hold[ch] = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        chk_model($sformatf("rnd%0d_rst", cyc));
        @(negedge clk);
        n_rst = 1'b1;
      end
      for (int ch = 0; ch < NCH; ch++) begin
        hold[ch]--;
        if (hold[ch] <= 0) begin
          if ($urandom_range(0, 1) == 1) sig[ch] = ~sig[ch];
          hold[ch] = $urandom_range(1, 8);
        end
        clear[ch] = ($urandom_range(0, 7) == 0);
      end
      if (cyc % 64 == 0) mode = 8'($urandom);
      if ($urandom_range(0, 49) == 0) filt_len = 4'($urandom_range(0, 5));
      tick();
      chk_model($sformatf("rnd%0d", cyc));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
